// File: rtl/freddy_list_ckpt.sv
// freddy_list_ckpt: R10K-style physical register free list and ready list
// with internal branch checkpoints.
//
// Up to WIDTH registers are handed to dispatch per cycle (lowest free indices
// first). CDB completions set ready bits. Retiring T_old registers return to
// the free list. NUM_CKPT free-list snapshots are held for branch recovery.
//
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   alloc_count      registers consumed by dispatch this cycle
//   alloc_idx        lane i = i-th lowest free register (combinational)
//   free_count       popcount of free_list (registered)
//   complete_valid   per-lane CDB valid
//   complete_idx     per-lane completing register
//   retire_count     retiring lanes 0..retire_count-1
//   retire_told      per-lane T_old being freed
//   ckpt_take        take a checkpoint at this edge
//   ckpt_id          slot the next take receives (lowest invalid slot)
//   ckpt_full        all checkpoint slots valid
//   br_valid         branch resolving this cycle
//   br_id            checkpoint of the resolving branch
//   br_mispredict    1 = restore and squash younger, 0 = release slot
//   free_list        1 = register free
//   ready_list       1 = register value complete
module freddy_list_ckpt #(
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned NUM_CKPT  = 4,
    localparam int unsigned IDX_W    = $clog2(PHYS_REGS),
    localparam int unsigned CNT_W    = $clog2(PHYS_REGS + 1),
    localparam int unsigned CK_W     = $clog2(NUM_CKPT),
    localparam int unsigned LN_W     = $clog2(WIDTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LN_W-1:0]        alloc_count,
    output logic [WIDTH*IDX_W-1:0] alloc_idx,
    output logic [CNT_W-1:0]       free_count,
    input  logic [WIDTH-1:0]       complete_valid,
    input  logic [WIDTH*IDX_W-1:0] complete_idx,
    input  logic [LN_W-1:0]        retire_count,
    input  logic [WIDTH*IDX_W-1:0] retire_told,
    input  logic                   ckpt_take,
    output logic [CK_W-1:0]        ckpt_id,
    output logic                   ckpt_full,
    input  logic                   br_valid,
    input  logic [CK_W-1:0]        br_id,
    input  logic                   br_mispredict,
    output logic [PHYS_REGS-1:0]   free_list,
    output logic [PHYS_REGS-1:0]   ready_list
);

    logic [PHYS_REGS-1:0] free_q, free_d;
    logic [PHYS_REGS-1:0] ready_q, ready_d;
    logic [CNT_W-1:0]     count_q;
    logic [PHYS_REGS-1:0] snap_q [NUM_CKPT];
    logic [NUM_CKPT-1:0]  age_q  [NUM_CKPT];
    logic [NUM_CKPT-1:0]  valid_q, valid_d;

    logic [PHYS_REGS-1:0] alloc_mask, retire_mask, complete_mask;
    logic [NUM_CKPT-1:0]  drop;
    logic                 mispredict, br_release, take;

    assign free_list  = free_q;
    assign ready_list = ready_q;
    assign free_count = count_q;

    assign mispredict = br_valid & br_mispredict;
    assign br_release = br_valid & ~br_mispredict;
    assign ckpt_full  = &valid_q;
    assign take       = ckpt_take & ~ckpt_full & ~mispredict;

    // Priority pick of the WIDTH lowest free registers.
    always_comb begin
        int unsigned lane;
        lane      = 0;
        alloc_idx = '0;
        for (int p = 0; p < PHYS_REGS; p++) begin
            if (free_q[p] && lane < WIDTH) begin
                alloc_idx[lane*IDX_W +: IDX_W] = IDX_W'(p);
                lane++;
            end
        end
    end

    // Lowest invalid slot; scanning downward leaves the lowest one last.
    always_comb begin
        ckpt_id = '0;
        for (int k = NUM_CKPT - 1; k >= 0; k--) begin
            if (!valid_q[k]) ckpt_id = CK_W'(k);
        end
    end

    always_comb begin
        alloc_mask    = '0;
        retire_mask   = '0;
        complete_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LN_W'(i) < alloc_count)  alloc_mask[alloc_idx[i*IDX_W +: IDX_W]]     = 1'b1;
            if (LN_W'(i) < retire_count) retire_mask[retire_told[i*IDX_W +: IDX_W]]  = 1'b1;
            if (complete_valid[i])       complete_mask[complete_idx[i*IDX_W +: IDX_W]] = 1'b1;
        end
    end

    // Slots leaving the valid set: the released slot, or on a mispredict the
    // resolving slot plus every slot whose age mask marks it as younger.
    always_comb begin
        drop = '0;
        if (br_valid) drop[br_id] = 1'b1;
        if (mispredict) begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                if (age_q[k][br_id]) drop[k] = 1'b1;
            end
        end
        valid_d = valid_q & ~drop;
        if (take) valid_d[ckpt_id] = 1'b1;
    end

    // Completion is applied last so a same-cycle alloc+complete ends ready.
    always_comb begin
        if (mispredict) begin
            free_d  = snap_q[br_id] | retire_mask;
            ready_d = ready_q | complete_mask;
        end else begin
            free_d  = (free_q & ~alloc_mask) | retire_mask;
            ready_d = (ready_q & ~alloc_mask) | complete_mask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_q  <= {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
            ready_q <= '1;
            count_q <= CNT_W'(PHYS_REGS - ARCH_REGS);
            valid_q <= '0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                snap_q[k] <= '0;
                age_q[k]  <= '0;
            end
        end else begin
            free_q  <= free_d;
            ready_q <= ready_d;
            count_q <= CNT_W'($countones(free_d));
            valid_q <= valid_d;
            for (int k = 0; k < NUM_CKPT; k++) begin
                // Retired regs must stay free after any later restore.
                if (valid_q[k]) snap_q[k] <= snap_q[k] | retire_mask;
                age_q[k] <= age_q[k] & ~drop;
            end
            if (take) begin
                snap_q[ckpt_id] <= free_d;
                age_q[ckpt_id]  <= valid_q & ~drop;
            end
        end
    end

    // Usage checks for simulation.
    always @(posedge clock) begin
        if (!reset) begin
            if (!mispredict) begin
                assert (alloc_count <= LN_W'(WIDTH) && CNT_W'(alloc_count) <= count_q)
                    else $error("alloc_count %0d exceeds available", alloc_count);
            end
            assert (!(ckpt_take && ckpt_full)) else $error("ckpt_take while full");
            assert (!br_valid || valid_q[br_id]) else $error("br_valid on invalid slot %0d", br_id);
            for (int i = 0; i < WIDTH; i++) begin
                if (LN_W'(i) < retire_count) begin
                    assert (!free_q[retire_told[i*IDX_W +: IDX_W]])
                        else $error("retiring free reg %0d", retire_told[i*IDX_W +: IDX_W]);
                    for (int j = 0; j < i; j++) begin
                        assert (retire_told[i*IDX_W +: IDX_W] != retire_told[j*IDX_W +: IDX_W])
                            else $error("duplicate retire reg");
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freddy_list_ckpt.sv
module tb_freddy_list_ckpt;

    localparam int P  = 64;
    localparam int A  = 32;
    localparam int W  = 3;
    localparam int NC = 4;
    localparam int IW = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      alloc_count, retire_count;
    logic [W*IW-1:0] alloc_idx, complete_idx, retire_told;
    logic [6:0]      free_count;
    logic [W-1:0]    complete_valid;
    logic            ckpt_take, ckpt_full, br_valid, br_mispredict;
    logic [1:0]      ckpt_id, br_id;
    logic [P-1:0]    free_list, ready_list;

    freddy_list_ckpt dut (
        .clock          (clock),
        .reset          (reset),
        .alloc_count    (alloc_count),
        .alloc_idx      (alloc_idx),
        .free_count     (free_count),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .retire_count   (retire_count),
        .retire_told    (retire_told),
        .ckpt_take      (ckpt_take),
        .ckpt_id        (ckpt_id),
        .ckpt_full      (ckpt_full),
        .br_valid       (br_valid),
        .br_id          (br_id),
        .br_mispredict  (br_mispredict),
        .free_list      (free_list),
        .ready_list     (ready_list)
    );

    always #5 clock = ~clock;

    // Reference model: sets of registers as bit arrays, checkpoints ordered
    // by a take sequence number (younger = larger number).
    bit m_free  [P];
    bit m_ready [P];
    bit m_snap  [NC][P];
    bit m_valid [NC];
    int m_seq   [NC];
    int seq_ctr;
    int checks = 0;
    int errors = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < P; i++) n += int'(m_free[i]);
        return n;
    endfunction

    function automatic int m_nth_free(input int n);
        int seen = 0;
        for (int i = 0; i < P; i++) begin
            if (m_free[i]) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic bit m_full();
        for (int k = 0; k < NC; k++) if (!m_valid[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_first_invalid();
        for (int k = 0; k < NC; k++) if (!m_valid[k]) return k;
        return 0;
    endfunction

    function automatic logic [P-1:0] m_pack_free();
        logic [P-1:0] v;
        for (int i = 0; i < P; i++) v[i] = m_free[i];
        return v;
    endfunction

    function automatic logic [P-1:0] m_pack_ready();
        logic [P-1:0] v;
        for (int i = 0; i < P; i++) v[i] = m_ready[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < P; i++) begin
            m_free[i]  = (i >= A);
            m_ready[i] = 1'b1;
        end
        for (int k = 0; k < NC; k++) m_valid[k] = 1'b0;
        seq_ctr = 0;
    endtask

    task automatic check(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int fc;
        fc = m_count();
        check("free_list", free_list, m_pack_free());
        check("ready_list", ready_list, m_pack_ready());
        check("free_count", P'(free_count), P'(fc));
        check("ckpt_full", P'(ckpt_full), P'(m_full()));
        if (!m_full()) check("ckpt_id", P'(ckpt_id), P'(m_first_invalid()));
        for (int i = 0; i < W && i < fc; i++)
            check("alloc_idx", P'(alloc_idx[i*IW +: IW]), P'(m_nth_free(i)));
    endtask

    task automatic idle();
        alloc_count    = '0;
        retire_count   = '0;
        retire_told    = '0;
        complete_valid = '0;
        complete_idx   = '0;
        ckpt_take      = 1'b0;
        br_valid       = 1'b0;
        br_id          = '0;
        br_mispredict  = 1'b0;
    endtask

    // Apply the current inputs to the model, clock the DUT, compare.
    task automatic cycle();
        int  al [$];
        bit  nfree [P];
        bit  mis, full;
        int  slot, s;
        mis  = br_valid && br_mispredict;
        full = m_full();
        slot = m_first_invalid();
        for (int i = 0; i < int'(alloc_count); i++) al.push_back(m_nth_free(i));
        for (int i = 0; i < P; i++) nfree[i] = mis ? m_snap[br_id][i] : m_free[i];
        if (!mis) foreach (al[j]) begin
            nfree[al[j]]   = 1'b0;
            m_ready[al[j]] = 1'b0;
        end
        for (int i = 0; i < int'(retire_count); i++) begin
            nfree[retire_told[i*IW +: IW]] = 1'b1;
            for (int k = 0; k < NC; k++)
                if (m_valid[k]) m_snap[k][retire_told[i*IW +: IW]] = 1'b1;
        end
        for (int i = 0; i < W; i++)
            if (complete_valid[i]) m_ready[complete_idx[i*IW +: IW]] = 1'b1;
        if (mis) begin
            s = m_seq[br_id];
            for (int k = 0; k < NC; k++) if (m_valid[k] && m_seq[k] >= s) m_valid[k] = 1'b0;
        end else begin
            if (br_valid) m_valid[br_id] = 1'b0;
            if (ckpt_take && !full) begin
                for (int i = 0; i < P; i++) m_snap[slot][i] = nfree[i];
                m_valid[slot] = 1'b1;
                m_seq[slot]   = seq_ctr++;
            end
        end
        for (int i = 0; i < P; i++) m_free[i] = nfree[i];
        @(posedge clock);
        #1;
        check_state();
    endtask

    task automatic random_inputs();
        int fc, rc, pick, nv;
        int busy [$];
        int vids [$];
        idle();
        fc = m_count();
        alloc_count = 2'($urandom_range(0, (fc < W) ? fc : W));
        for (int k = 0; k < NC; k++) if (m_valid[k]) vids.push_back(k);
        nv = vids.size();
        if (nv > 0 && $urandom_range(0, 3) == 0) begin
            br_valid      = 1'b1;
            br_id         = 2'(vids[$urandom_range(0, nv - 1)]);
            br_mispredict = 1'($urandom_range(0, 1));
        end
        if (!m_full() && $urandom_range(0, 2) == 0) ckpt_take = 1'b1;
        for (int i = 0; i < P; i++) if (!m_free[i]) busy.push_back(i);
        rc = $urandom_range(0, (busy.size() < W) ? busy.size() : W);
        retire_count = 2'(rc);
        for (int i = 0; i < rc; i++) begin
            pick = $urandom_range(0, busy.size() - 1);
            retire_told[i*IW +: IW] = IW'(busy[pick]);
            busy.delete(pick);
        end
        complete_valid = W'($urandom);
        complete_idx   = (W*IW)'($urandom);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_state();
        check("rst_free_const", free_list, 64'hFFFF_FFFF_0000_0000);
        check("rst_alloc_const", P'(alloc_idx), P'({6'd34, 6'd33, 6'd32}));
        check("rst_count_const", P'(free_count), P'(32));

        // Allocate three.
        alloc_count = 2'd3;
        cycle();
        check("alloc3_count", P'(free_count), P'(29));
        check("alloc3_next", P'(alloc_idx), P'({6'd37, 6'd36, 6'd35}));
        check("alloc3_ready", P'(ready_list[34:32]), P'(3'b000));

        // Partial completion.
        idle();
        complete_valid = 3'b101;
        complete_idx   = {6'd34, 6'd0, 6'd32};
        cycle();
        check("complete_ready", P'(ready_list[34:32]), P'(3'b101));

        // Checkpoint with one alloc, more allocs, a retire, then restore.
        idle();
        ckpt_take   = 1'b1;
        alloc_count = 2'd1;
        cycle();
        idle();
        alloc_count = 2'd3;
        cycle();
        idle();
        retire_count = 2'd1;
        retire_told  = {6'd0, 6'd0, 6'd5};
        cycle();
        idle();
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_id         = 2'd0;
        cycle();
        check("restore_free", free_list, 64'hFFFF_FFF0_0000_0020);
        check("restore_count", P'(free_count), P'(29));

        // Fill all checkpoints, release one, squash from the oldest.
        idle();
        ckpt_take = 1'b1;
        repeat (NC) cycle();
        check("ckpt_full_set", P'(ckpt_full), P'(1));
        idle();
        br_valid = 1'b1;
        br_id    = 2'd1;
        cycle();
        check("release_full", P'(ckpt_full), P'(0));
        check("release_id", P'(ckpt_id), P'(1));
        idle();
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_id         = 2'd0;
        cycle();
        check("squash_id", P'(ckpt_id), P'(0));
        idle();
        ckpt_take = 1'b1;
        repeat (2) cycle();
        check("squash_younger", P'(ckpt_id), P'(2));
        idle();
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_id         = 2'd0;
        cycle();

        // Mispredict with same-cycle retire, then an async reset pulse.
        idle();
        ckpt_take   = 1'b1;
        alloc_count = 2'd2;
        cycle();
        idle();
        alloc_count = 2'd2;
        cycle();
        idle();
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_id         = 2'd0;
        retire_count  = 2'd2;
        retire_told   = {6'd0, 6'd8, 6'd7};
        cycle();
        check("mis_retire", P'(free_list[8:7]), P'(2'b11));
        idle();
        #1 reset = 1'b1;
        model_reset();
        #1 check_state();
        check("async_rst_free", free_list, 64'hFFFF_FFFF_0000_0000);
        #1 reset = 1'b0;

        // Randomised traffic with one mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                idle();
                #2 reset = 1'b1;
                model_reset();
                #1 check_state();
                #1 reset = 1'b0;
            end
            random_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
